// File: rtl/sift_desc_tx.sv
// Two-entry ping-pong descriptor buffer feeding a byte-framed valid/ready stream.
// Optional trailing XOR checksum byte is enabled by defining SIFT_DESC_TX_CKSUM_EN.
module sift_desc_tx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         DESC_BYTES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DESC_BYTES-1:0] desc_in,
    input  logic                    desc_valid,
    input  logic [9:0]              kp_idx_in,
    input  logic [5:0]              main_dir_in,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    frame_last,
    output logic                    busy,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    localparam int                DESC_W   = 8 * DESC_BYTES;
    localparam int                CNT_W    = $clog2(DESC_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DESC_BYTES - 1);

`ifdef SIFT_DESC_TX_CKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_HDR1, S_HDR2, S_PAYLOAD, S_CKSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_HDR1, S_HDR2, S_PAYLOAD
    } state_t;
`endif

    logic [DESC_W-1:0] desc_mem_q [2];
    logic [9:0]        kp_mem_q   [2];
    logic [5:0]        dir_mem_q  [2];

    state_t            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_last_q, frame_last_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`ifdef SIFT_DESC_TX_CKSUM_EN
    logic [7:0]        acc_q, acc_d;
`endif

    logic              capture;
    logic              accept;
    logic              frame_done;
    logic [DESC_W-1:0] rd_desc;
    logic [9:0]        rd_kp;
    logic [5:0]        rd_dir;
    logic [CNT_W-1:0]  nxt_idx;

    assign rd_desc    = desc_mem_q[rd_ptr_q];
    assign rd_kp      = kp_mem_q[rd_ptr_q];
    assign rd_dir     = dir_mem_q[rd_ptr_q];
    assign nxt_idx    = cnt_q + CNT_W'(1);
    assign accept     = byte_valid_q & byte_ready;
    assign frame_done = accept & frame_last_q;

    // NOTE: every variable gets its default before any branch, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        frame_last_d = frame_last_q;
        overflow_d   = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        capture      = 1'b0;
`ifdef SIFT_DESC_TX_CKSUM_EN
        acc_d        = acc_q;
`endif

        // Free the read slot before deciding on capture, so a full buffer whose
        // last byte leaves on this edge still accepts the incoming descriptor.
        if (frame_done) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end

        if (desc_valid) begin
            if (!full_d[wr_ptr_q]) begin
                capture          = 1'b1;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|full_q) begin
                    state_d      = S_SYNC;
                    byte_out_d   = SYNC_BYTE;
                    byte_valid_d = 1'b1;
                    frame_last_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (accept) begin
                    state_d    = S_HDR1;
                    byte_out_d = rd_kp[7:0];
                end
            end
            S_HDR1: begin
                if (accept) begin
                    state_d    = S_HDR2;
                    byte_out_d = {rd_kp[9:8], rd_dir};
                end
            end
            S_HDR2: begin
                if (accept) begin
                    state_d    = S_PAYLOAD;
                    cnt_d      = '0;
                    byte_out_d = rd_desc[7:0];
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
`ifdef SIFT_DESC_TX_CKSUM_EN
                        state_d      = S_CKSUM;
                        byte_out_d   = acc_q ^ byte_out_q;
                        frame_last_d = 1'b1;
`endif
                    end else begin
                        cnt_d      = nxt_idx;
                        byte_out_d = rd_desc[{nxt_idx, 3'b000} +: 8];
`ifdef SIFT_DESC_TX_CKSUM_EN
                        frame_last_d = 1'b0;
`else
                        frame_last_d = (nxt_idx == LAST_IDX);
`endif
                    end
                end
            end
`ifdef SIFT_DESC_TX_CKSUM_EN
            S_CKSUM: begin
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // End of frame: chain straight into the next frame when the other slot holds one.
        if (frame_done) begin
            frame_last_d = 1'b0;
            if (full_d[rd_ptr_d]) begin
                state_d      = S_SYNC;
                byte_out_d   = SYNC_BYTE;
                byte_valid_d = 1'b1;
            end else begin
                state_d      = S_IDLE;
                byte_out_d   = 8'h00;
                byte_valid_d = 1'b0;
            end
        end

`ifdef SIFT_DESC_TX_CKSUM_EN
        if (state_q == S_SYNC) begin
            acc_d = 8'h00;
        end else if (accept && (state_q == S_HDR1 || state_q == S_HDR2 ||
                                state_q == S_PAYLOAD)) begin
            acc_d = acc_q ^ byte_out_q;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            full_q       <= 2'b00;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_last_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'h00;
`ifdef SIFT_DESC_TX_CKSUM_EN
            acc_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_last_q <= frame_last_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef SIFT_DESC_TX_CKSUM_EN
            acc_q        <= acc_d;
`endif
        end
    end

    // NOTE: buffer storage is not reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            desc_mem_q[wr_ptr_q] <= desc_in;
            kp_mem_q[wr_ptr_q]   <= kp_idx_in;
            dir_mem_q[wr_ptr_q]  <= main_dir_in;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_last = frame_last_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (|full_q) || (state_q != S_IDLE);

endmodule
